// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl
//   Run/stop controller and sequencer for an NDIG-digit cascaded BCD up/down
//   counter. It holds the digit chain, derives the count step from a clk
//   prescaler, and handles start/stop/clear/preset and terminal count (wrap or
//   hold at limit).
//
//   Optional feature macro: DISPLAY_SCAN_EN (adds multiplexed 7-segment scan
//   outputs an/seg). With the macro undefined those ports and that logic are
//   absent.
//
// Ports
//   clk    in   system clock, posedge
//   s      in   asynchronous active-high reset
//   start  in   level, request RUN
//   stop   in   level, request IDLE
//   clr    in   level, clear chain to 0 and go IDLE
//   up     in   direction, 1 = up, 0 = down
//   load   in   level, preset chain from din (ignored in RUN)
//   din    in   preset value, digit 0 = din[3:0]
//   Q      out  BCD chain value, digit 0 = Q[3:0]
//   run    out  1 while in RUN
//   tc     out  combinational terminal count for the current direction
//   ovf    out  one-cycle pulse on a terminal-count step
//   an     out  active-low one-hot digit select      (DISPLAY_SCAN_EN)
//   seg    out  active-low segments of selected digit (DISPLAY_SCAN_EN)
//
// State | meaning
// IDLE  | chain frozen, waiting for start
// RUN   | prescaler running, chain steps on each tick
// HOLD  | frozen at terminal count (WRAP=0), start needs tc==0
module decade_chain_ctrl #(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 50000,
   parameter int WRAP     = 0,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              s,
   input  logic              start,
   input  logic              stop,
   input  logic              clr,
   input  logic              up,
   input  logic              load,
   input  logic [4*NDIG-1:0] din,
   output logic [4*NDIG-1:0] Q,
   output logic              run,
   output logic              tc,
   output logic              ovf
`ifdef DISPLAY_SCAN_EN
   ,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        seg
`endif
);

   if (NDIG < 1 || NDIG > 8 || PRESCALE < 2 || SCAN_DIV < 1) begin : g_bad_param
      $error("decade_chain_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   localparam int            PW    = $clog2(PRESCALE);
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   state_t            state;
   logic [PW-1:0]     presc;
   logic              tick;
   logic              all_nine;
   logic              all_zero;
   logic              carry;
   logic [4*NDIG-1:0] q_step;
   logic [4*NDIG-1:0] q_load;

   assign tick = (state == RUN) && (presc == PLAST);

   // Ripple-enable chain: digit k steps only when every lower digit sits at
   // the terminal value for the current direction.
   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      carry    = 1'b1;
      q_step   = Q;
      q_load   = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (Q[4*k +: 4] != 4'd9) all_nine = 1'b0;
         if (Q[4*k +: 4] != 4'd0) all_zero = 1'b0;
         if (carry) begin
            if (up) q_step[4*k +: 4] = (Q[4*k +: 4] == 4'd9) ? 4'd0 : Q[4*k +: 4] + 4'd1;
            else    q_step[4*k +: 4] = (Q[4*k +: 4] == 4'd0) ? 4'd9 : Q[4*k +: 4] - 4'd1;
         end
         carry = carry & (up ? (Q[4*k +: 4] == 4'd9) : (Q[4*k +: 4] == 4'd0));
         // non-BCD preset nibbles saturate to 9
         q_load[4*k +: 4] = (din[4*k +: 4] > 4'd9) ? 4'd9 : din[4*k +: 4];
      end
      tc = up ? all_nine : all_zero;
   end

   always_ff @(posedge clk or posedge s) begin
      if (s) begin
         state <= IDLE;
         presc <= '0;
         Q     <= '0;
         run   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         ovf <= 1'b0;
         if (clr) begin
            Q     <= '0;
            presc <= '0;
            state <= IDLE;
            run   <= 1'b0;
         end else if (load && state != RUN) begin
            Q     <= q_load;
            presc <= '0;
            state <= IDLE;
            run   <= 1'b0;
         end else if (stop) begin
            presc <= '0;
            state <= IDLE;
            run   <= 1'b0;
         end else if (start && (state == IDLE || (state == HOLD && !tc))) begin
            presc <= '0;
            state <= RUN;
            run   <= 1'b1;
         end else if (state == RUN) begin
            if (tick) begin
               presc <= '0;
               if (tc) begin
                  ovf <= 1'b1;
                  if (WRAP != 0) begin
                     Q <= q_step;
                  end else begin
                     state <= HOLD;
                     run   <= 1'b0;
                  end
               end else begin
                  Q <= q_step;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

`ifdef DISPLAY_SCAN_EN
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [SW-1:0] scan_cnt;
   logic [DW-1:0] slot;

   // seg[6] = a ... seg[0] = g, active low
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'h01;
         4'd1:    seg_of = 7'h4F;
         4'd2:    seg_of = 7'h12;
         4'd3:    seg_of = 7'h06;
         4'd4:    seg_of = 7'h4C;
         4'd5:    seg_of = 7'h24;
         4'd6:    seg_of = 7'h20;
         4'd7:    seg_of = 7'h0F;
         4'd8:    seg_of = 7'h00;
         4'd9:    seg_of = 7'h04;
         default: seg_of = 7'h7F;
      endcase
   endfunction

   always_ff @(posedge clk or posedge s) begin
      if (s) begin
         scan_cnt <= '0;
         slot     <= '0;
         an       <= '1;
         seg      <= 7'h7F;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            slot     <= (slot == DW'(NDIG - 1)) ? '0 : slot + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an  <= ~(NDIG'(1) << slot);
         seg <= seg_of(Q[4*slot +: 4]);
      end
   end
`endif

endmodule

// File: tb/tb_decade_chain_ctrl.sv
module tb_decade_chain_ctrl;
   logic        clk = 1'b0;
   logic        rst0 = 1'b1;
   logic        rst1 = 1'b1;
   logic        start = 1'b0, stop = 1'b0, clr = 1'b0, up = 1'b1, load = 1'b0;
   logic [15:0] din = '0;
   logic [15:0] q0, q1;
   logic        run0, run1, tc0, tc1, ovf0, ovf1;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   bit done = 1'b0;

   typedef struct {
      int          t;
      logic [15:0] q;
      logic        run;
      logic        ovf;
   } ev_t;

   ev_t sb0[$];
   ev_t sb1[$];

   // dut0 holds at the limit, dut1 wraps; both see the same command inputs
   decade_chain_ctrl #(.NDIG(4), .PRESCALE(4), .WRAP(0), .SCAN_DIV(2)) dut0 (
      .clk(clk), .s(rst0), .start(start), .stop(stop), .clr(clr), .up(up),
      .load(load), .din(din), .Q(q0), .run(run0), .tc(tc0), .ovf(ovf0));

   decade_chain_ctrl #(.NDIG(4), .PRESCALE(4), .WRAP(1), .SCAN_DIV(2)) dut1 (
      .clk(clk), .s(rst1), .start(start), .stop(stop), .clr(clr), .up(up),
      .load(load), .din(din), .Q(q1), .run(run1), .tc(tc1), .ovf(ovf1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input int idx, input logic [15:0] q, input logic r, input logic o);
      ev_t e;
      if ((idx == 0 && sb0.size() == 0) || (idx == 1 && sb1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL dut%0d unexpected event at cyc %0d: Q=%h run=%b ovf=%b", idx, cyc, q, r, o);
      end else begin
         e = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
         chk($sformatf("dut%0d event cycle", idx), cyc, e.t);
         chk($sformatf("dut%0d Q @%0d", idx, e.t), {16'h0, q}, {16'h0, e.q});
         chk($sformatf("dut%0d run @%0d", idx, e.t), {31'h0, r}, {31'h0, e.run});
         chk($sformatf("dut%0d ovf @%0d", idx, e.t), {31'h0, o}, {31'h0, e.ovf});
      end
   endtask

   // Monitor: any change of Q/run, or an ovf pulse, is an output event.
   logic [15:0] lq0 = '0, lq1 = '0;
   logic        lr0 = 1'b0, lr1 = 1'b0;
   always @(negedge clk) begin
      if (rst0) begin
         lq0 = '0; lr0 = 1'b0;
      end else if (q0 !== lq0 || run0 !== lr0 || ovf0 !== 1'b0) begin
         pop_cmp(0, q0, run0, ovf0);
         lq0 = q0; lr0 = run0;
      end
      if (rst1) begin
         lq1 = '0; lr1 = 1'b0;
      end else if (q1 !== lq1 || run1 !== lr1 || ovf1 !== 1'b0) begin
         pop_cmp(1, q1, run1, ovf1);
         lq1 = q1; lr1 = run1;
      end
   end

   function automatic ev_t mk(input int t, input logic [15:0] q, input logic r, input logic o);
      ev_t e;
      e.t = t; e.q = q; e.run = r; e.ovf = o;
      return e;
   endfunction

   task automatic wait_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one command for exactly one sampling edge; t is the cycle before it.
   task automatic issue(input logic c_clr, input logic c_load, input logic c_stop,
                        input logic c_start, input logic [15:0] d, output int t);
      clr = c_clr; load = c_load; stop = c_stop; start = c_start; din = d;
      t = cyc;
      @(posedge clk);
      #1;
      clr = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
   endtask

   initial begin
      int t;
      int ts;
      #12;
      chk("reset Q", {16'h0, q0}, 32'h0);
      chk("reset run", {31'h0, run0}, 32'h0);
      chk("reset ovf", {31'h0, ovf0}, 32'h0);
      chk("tc up at 0000", {31'h0, tc0}, 32'h0);
      up = 1'b0;
      #1;
      chk("tc down at 0000", {31'h0, tc0}, 32'h1);
      up = 1'b1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      @(posedge clk); #1;

      // load 0998, count up across two carries, stop on a tick cycle
      issue(0, 1, 0, 0, 16'h0998, t);  sb0.push_back(mk(t + 1, 16'h0998, 0, 0));
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1,  16'h0998, 1, 0));
      sb0.push_back(mk(ts + 5,  16'h0999, 1, 0));
      sb0.push_back(mk(ts + 9,  16'h1000, 1, 0));
      sb0.push_back(mk(ts + 13, 16'h1001, 1, 0));
      wait_to(ts + 16);
      issue(0, 0, 1, 0, 16'h0, t);     sb0.push_back(mk(t + 1, 16'h1001, 0, 0));

      // down count with borrow through three digits
      issue(0, 1, 0, 0, 16'h1000, t);  sb0.push_back(mk(t + 1, 16'h1000, 0, 0));
      up = 1'b0;
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h1000, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h0999, 1, 0));
      wait_to(ts + 6);
      issue(0, 0, 1, 0, 16'h0, t);     sb0.push_back(mk(t + 1, 16'h0999, 0, 0));

      // hold at terminal count, start ignored until direction flips
      up = 1'b1;
      issue(0, 1, 0, 0, 16'h9998, t);  sb0.push_back(mk(t + 1, 16'h9998, 0, 0));
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h9998, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h9999, 1, 0));
      sb0.push_back(mk(ts + 9, 16'h9999, 0, 1));
      wait_to(ts + 11);
      chk("tc in HOLD up", {31'h0, tc0}, 32'h1);
      issue(0, 0, 0, 1, 16'h0, t);
      wait_to(cyc + 2);
      up = 1'b0;
      #1;
      chk("tc in HOLD down", {31'h0, tc0}, 32'h0);
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h9999, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h9998, 1, 0));
      wait_to(ts + 6);
      issue(0, 0, 1, 0, 16'h0, t);     sb0.push_back(mk(t + 1, 16'h9998, 0, 0));

      // saturating preset, load ignored in RUN, clr on an ordinary tick
      up = 1'b1;
      issue(0, 1, 0, 0, 16'hFA93, t);  sb0.push_back(mk(t + 1, 16'h9993, 0, 0));
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h9993, 1, 0));
      wait_to(ts + 2);
      issue(0, 1, 0, 0, 16'h1234, t);
      sb0.push_back(mk(ts + 5, 16'h9994, 1, 0));
      wait_to(ts + 8);
      issue(1, 0, 0, 0, 16'h0, t);     sb0.push_back(mk(t + 1, 16'h0000, 0, 0));

      // clr on a terminal-count tick: no ovf
      issue(0, 1, 0, 0, 16'h9999, t);  sb0.push_back(mk(t + 1, 16'h9999, 0, 0));
      issue(0, 0, 0, 1, 16'h0, ts);    sb0.push_back(mk(ts + 1, 16'h9999, 1, 0));
      wait_to(ts + 4);
      issue(1, 0, 0, 0, 16'h0, t);     sb0.push_back(mk(t + 1, 16'h0000, 0, 0));

      // clr and load together in HOLD: clr wins
      issue(0, 1, 0, 0, 16'h9999, t);  sb0.push_back(mk(t + 1, 16'h9999, 0, 0));
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h9999, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h9999, 0, 1));
      wait_to(ts + 7);
      issue(1, 1, 0, 0, 16'h5555, t);  sb0.push_back(mk(t + 1, 16'h0000, 0, 0));

      // down from 0000: dut0 holds, dut1 wraps to 9999
      rst1 = 1'b0;
      @(posedge clk); #1;
      up = 1'b0;
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h0000, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h0000, 0, 1));
      sb1.push_back(mk(ts + 1, 16'h0000, 1, 0));
      sb1.push_back(mk(ts + 5, 16'h9999, 1, 1));
      sb1.push_back(mk(ts + 9, 16'h9998, 1, 0));
      wait_to(ts + 10);
      issue(0, 0, 1, 0, 16'h0, t);     sb1.push_back(mk(t + 1, 16'h9998, 0, 0));

      // asynchronous reset mid-RUN, while dut1 is showing an ovf pulse
      up = 1'b1;
      issue(0, 0, 0, 1, 16'h0, ts);
      sb0.push_back(mk(ts + 1, 16'h0000, 1, 0));
      sb0.push_back(mk(ts + 5, 16'h0001, 1, 0));
      sb0.push_back(mk(ts + 9, 16'h0002, 1, 0));
      sb1.push_back(mk(ts + 1, 16'h9998, 1, 0));
      sb1.push_back(mk(ts + 5, 16'h9999, 1, 0));
      sb1.push_back(mk(ts + 9, 16'h0000, 1, 1));
      wait_to(ts + 9);
      #6;
      chk("dut1 ovf before reset", {31'h0, ovf1}, 32'h1);
      rst0 = 1'b1;
      rst1 = 1'b1;
      #1;
      chk("async reset Q dut0", {16'h0, q0}, 32'h0);
      chk("async reset run dut0", {31'h0, run0}, 32'h0);
      chk("async reset Q dut1", {16'h0, q1}, 32'h0);
      chk("async reset run dut1", {31'h0, run1}, 32'h0);
      chk("async reset ovf dut1", {31'h0, ovf1}, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      wait_to(cyc + 8);
      chk("dut0 events pending", sb0.size(), 0);
      chk("dut1 events pending", sb1.size(), 0);
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL watchdog: got timeout expected completion");
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end
endmodule
